// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end.
// Issues sequential fetch addresses to instruction memory over a
// request/ready interface, tags each accepted request with its PC, collects
// the in-order responses into a small FIFO and presents the FIFO head to the
// IF/ID register. A taken branch flushes everything in flight and refetches
// from the branch target.
//
// Credit scheme: a request is only issued while (outstanding + count) is
// below DEPTH, so every response is guaranteed a free FIFO slot and the
// FIFO can never overflow.
//
// Redirect handling: requests already issued to memory cannot be recalled.
// Instead, the number of responses still owed is latched into 'stale', and
// that many responses are dropped as they arrive. A response arriving in
// the redirect cycle itself is dropped directly and is not counted in stale.

module if_fetch_unit #(
    parameter int unsigned PC_W     = 16,
    parameter int unsigned INSTN_W  = 32,
    parameter int unsigned PC_STEP  = 4,
    parameter int unsigned RESET_PC = 32'd0,
    parameter int unsigned DEPTH    = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    // Redirect from the branch unit
    input  logic               beq_enable,
    input  logic [PC_W-1:0]    beq_target,
    // Instruction memory request channel
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ready,
    // Instruction memory response channel (in request order)
    input  logic               imem_rvalid,
    input  logic [INSTN_W-1:0] imem_rdata,
    // Towards the IF/ID pipeline register
    output logic [PC_W-1:0]    IF_PC,
    output logic [INSTN_W-1:0] instn,
    output logic               if_valid
);

    // Pointer width into DEPTH-entry circular buffers, counter width 0..DEPTH
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    // Circular-buffer pointer advance; DEPTH need not be a power of two
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p == PTR_W'(DEPTH - 1)) begin
            r = '0;
        end else begin
            r = p + PTR_W'(1);
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PC_W-1:0]    fetch_pc_q,    fetch_pc_d;
    logic [CNT_W-1:0]   outstanding_q, outstanding_d;
    logic [CNT_W-1:0]   stale_q,       stale_d;

    // PC tag queue: one entry per outstanding request
    logic [PC_W-1:0]    tag_q [DEPTH];
    logic [PTR_W-1:0]   tag_wr_q, tag_wr_d;
    logic [PTR_W-1:0]   tag_rd_q, tag_rd_d;

    // Instruction FIFO: {pc, instn} pairs awaiting presentation
    logic [PC_W-1:0]    fifo_pc_q    [DEPTH];
    logic [INSTN_W-1:0] fifo_instn_q [DEPTH];
    logic [PTR_W-1:0]   fifo_wr_q, fifo_wr_d;
    logic [PTR_W-1:0]   fifo_rd_q, fifo_rd_d;
    logic [CNT_W-1:0]   count_q,   count_d;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic [CNT_W:0]     credit_sum_s;
    logic               req_s;
    logic               acc_s;
    logic               resp_s;
    logic               push_s;
    logic               valid_s;
    logic [PC_W-1:0]    if_pc_s;
    logic [INSTN_W-1:0] instn_s;

    // Credits in use: requests in memory plus words waiting in the FIFO
    assign credit_sum_s = {1'b0, outstanding_q} + {1'b0, count_q};

    // Request is a function of local state and the redirect only, never of
    // imem_ready; it is held low while reset is asserted.
    assign req_s  = rst_n && !beq_enable &&
                    (credit_sum_s < (CNT_W + 1)'(DEPTH));
    assign acc_s  = req_s && imem_ready;

    // A response with nothing outstanding is a protocol violation: ignore it
    assign resp_s = imem_rvalid && (outstanding_q != '0);

    // Responses are kept only when not owed to a flushed stream and not
    // arriving in a redirect cycle
    assign push_s = resp_s && (stale_q == '0) && !beq_enable;

    // Head is presented (and popped) whenever the FIFO holds a word
    assign valid_s = (count_q != '0) && !beq_enable;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------

    // Fetch address: redirect target wins, otherwise advance on acceptance
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (beq_enable) begin
            fetch_pc_d = beq_target;
        end else if (acc_s) begin
            fetch_pc_d = fetch_pc_q + PC_W'(PC_STEP);
        end else begin
            fetch_pc_d = fetch_pc_q;
        end
    end

    // Outstanding-request and stale-response bookkeeping
    always_comb begin
        outstanding_d = outstanding_q + CNT_W'(acc_s) - CNT_W'(resp_s);
        stale_d       = stale_q;
        if (beq_enable) begin
            // No request is accepted in a redirect cycle, so every request
            // still owed after this cycle's response belongs to the old stream
            stale_d = outstanding_q - CNT_W'(resp_s);
        end else if (resp_s && (stale_q != '0)) begin
            stale_d = stale_q - CNT_W'(1);
        end else begin
            stale_d = stale_q;
        end
    end

    // PC tag queue pointers: push on acceptance, pop on every response
    always_comb begin
        tag_wr_d = tag_wr_q;
        tag_rd_d = tag_rd_q;
        if (acc_s) begin
            tag_wr_d = ptr_inc(tag_wr_q);
        end else begin
            tag_wr_d = tag_wr_q;
        end
        if (resp_s) begin
            tag_rd_d = ptr_inc(tag_rd_q);
        end else begin
            tag_rd_d = tag_rd_q;
        end
    end

    // Instruction FIFO pointers and occupancy; a redirect empties it
    always_comb begin
        fifo_wr_d = fifo_wr_q;
        fifo_rd_d = fifo_rd_q;
        count_d   = count_q;
        if (beq_enable) begin
            fifo_wr_d = '0;
            fifo_rd_d = '0;
            count_d   = '0;
        end else begin
            if (push_s) begin
                fifo_wr_d = ptr_inc(fifo_wr_q);
            end else begin
                fifo_wr_d = fifo_wr_q;
            end
            if (valid_s) begin
                fifo_rd_d = ptr_inc(fifo_rd_q);
            end else begin
                fifo_rd_d = fifo_rd_q;
            end
            count_d = count_q + CNT_W'(push_s) - CNT_W'(valid_s);
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    // Control state: fetch PC, counters and pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= PC_W'(RESET_PC);
            outstanding_q <= '0;
            stale_q       <= '0;
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
            fifo_wr_q     <= '0;
            fifo_rd_q     <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            stale_q       <= stale_d;
            tag_wr_q      <= tag_wr_d;
            tag_rd_q      <= tag_rd_d;
            fifo_wr_q     <= fifo_wr_d;
            fifo_rd_q     <= fifo_rd_d;
            count_q       <= count_d;
        end
    end

    // PC tag storage: record the address of each accepted request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                tag_q[i] <= '0;
            end
        end else if (acc_s) begin
            tag_q[tag_wr_q] <= fetch_pc_q;
        end
    end

    // FIFO storage: pair each kept response with its tagged PC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_pc_q[i]    <= '0;
                fifo_instn_q[i] <= '0;
            end
        end else if (push_s) begin
            fifo_pc_q[fifo_wr_q]    <= tag_q[tag_rd_q];
            fifo_instn_q[fifo_wr_q] <= imem_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------

    // Present the FIFO head; drive zeros (PC 0, NOP) when nothing is valid
    always_comb begin
        if_pc_s = '0;
        instn_s = '0;
        if (valid_s) begin
            if_pc_s = fifo_pc_q[fifo_rd_q];
            instn_s = fifo_instn_q[fifo_rd_q];
        end else begin
            if_pc_s = '0;
            instn_s = '0;
        end
    end

    assign imem_req  = req_s;
    assign imem_addr = fetch_pc_q;
    assign IF_PC     = if_pc_s;
    assign instn     = instn_s;
    assign if_valid  = valid_s;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: a table of per-cycle vectors for
// the 1-cycle-memory stream, hand-written redirect sequences, a random
// ready/latency stream check, and a second instance for PC wrap-around.

module tb_if_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (default parameters)
    logic        rst_n;
    logic        beq_enable;
    logic [15:0] beq_target;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [15:0] IF_PC;
    logic [31:0] instn;
    logic        if_valid;

    // Second instance, reset PC near the top of the address space
    logic        rst1_n;
    logic        beq1;
    logic [15:0] tgt1;
    logic        req1;
    logic [15:0] addr1;
    logic        ready1;
    logic        rvalid1;
    logic [31:0] rdata1;
    logic [15:0] pc1;
    logic [31:0] instn1;
    logic        valid1;

    if_fetch_unit dut (
        .clk(clk), .rst_n(rst_n),
        .beq_enable(beq_enable), .beq_target(beq_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .IF_PC(IF_PC), .instn(instn), .if_valid(if_valid)
    );

    if_fetch_unit #(.RESET_PC(32'h0000_FFF8)) dut_wrap (
        .clk(clk), .rst_n(rst1_n),
        .beq_enable(beq1), .beq_target(tgt1),
        .imem_req(req1), .imem_addr(addr1), .imem_ready(ready1),
        .imem_rvalid(rvalid1), .imem_rdata(rdata1),
        .IF_PC(pc1), .instn(instn1), .if_valid(valid1)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // Memory model: in-order responses with configurable latency
    typedef struct {
        logic [15:0] addr;
        int          due;
    } pend_t;
    pend_t pq[$];
    int    last_due;
    bit    mem_auto;
    int    lat_min, lat_max;

    // Sampled DUT outputs for the current cycle
    logic        s_req, s_valid, s1_req;
    logic [15:0] s_addr, s_pc, s1_addr;
    logic [31:0] s_instn;

    typedef struct {
        bit          ready;
        bit          req;
        logic [15:0] addr;
        bit          valid;
        logic [15:0] pc;
    } vec_t;
    vec_t tbl [12];

    function automatic logic [31:0] word_of(input logic [15:0] a);
        return 32'hA000_0000 | {16'h0000, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // One clock cycle: drive memory response, sample outputs, advance
    task automatic cycle();
        int lat, due;
        if (mem_auto) begin
            if (pq.size() > 0 && pq[0].due <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = word_of(pq[0].addr);
                void'(pq.pop_front());
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = 32'h0;
            end
        end
        #1;
        s_req = imem_req;  s_addr = imem_addr;  s_valid = if_valid;
        s_pc  = IF_PC;     s_instn = instn;
        s1_req = req1;     s1_addr = addr1;
        if (mem_auto && s_req && imem_ready) begin
            lat = int'($urandom_range(lat_max, lat_min));
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            pq.push_back('{s_addr, due});
            last_due = due;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic mstep(input bit b, input logic [15:0] t, input bit rdy,
                         input bit rv, input logic [31:0] rd);
        beq_enable = b; beq_target = t; imem_ready = rdy;
        imem_rvalid = rv; imem_rdata = rd;
        cycle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; beq_enable = 1'b0; beq_target = 16'h0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        pq.delete(); last_due = -1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", {31'h0, if_valid}, 32'h0);
        chk("rst_pc",    {16'h0, IF_PC},    32'h0);
        chk("rst_instn", instn,             32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepted, presented;
        logic [15:0] exp_pc;

        rst1_n = 1'b0; beq1 = 1'b0; tgt1 = 16'h0; ready1 = 1'b1;
        rvalid1 = 1'b0; rdata1 = 32'h0;

        // ready, req, addr, valid, pc  (1-cycle memory from reset release)
        tbl[0]  = '{1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000};
        tbl[1]  = '{1'b1, 1'b1, 16'h0004, 1'b0, 16'h0000};
        tbl[2]  = '{1'b1, 1'b1, 16'h0008, 1'b1, 16'h0000};
        tbl[3]  = '{1'b1, 1'b1, 16'h000C, 1'b1, 16'h0004};
        tbl[4]  = '{1'b1, 1'b1, 16'h0010, 1'b1, 16'h0008};
        tbl[5]  = '{1'b1, 1'b1, 16'h0014, 1'b1, 16'h000C};
        tbl[6]  = '{1'b1, 1'b1, 16'h0018, 1'b1, 16'h0010};
        tbl[7]  = '{1'b1, 1'b1, 16'h001C, 1'b1, 16'h0014};
        tbl[8]  = '{1'b0, 1'b1, 16'h0020, 1'b1, 16'h0018};
        tbl[9]  = '{1'b1, 1'b1, 16'h0020, 1'b1, 16'h001C};
        tbl[10] = '{1'b1, 1'b1, 16'h0024, 1'b0, 16'h0000};
        tbl[11] = '{1'b1, 1'b1, 16'h0028, 1'b1, 16'h0020};

        // ---- Table: sequential fetch with 1-cycle memory ----
        mem_auto = 1'b1; lat_min = 1; lat_max = 1;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            imem_ready = tbl[i].ready;
            cycle();
            chk("tbl_req",   {31'h0, s_req},   {31'h0, tbl[i].req});
            chk("tbl_addr",  {16'h0, s_addr},  {16'h0, tbl[i].addr});
            chk("tbl_valid", {31'h0, s_valid}, {31'h0, tbl[i].valid});
            chk("tbl_pc",    {16'h0, s_pc},    {16'h0, tbl[i].pc});
            chk("tbl_instn", s_instn, tbl[i].valid ? word_of(tbl[i].pc) : 32'h0);
        end

        // ---- Asynchronous reset mid-stream ----
        #1;
        chk("pre_rst_valid", {31'h0, if_valid}, 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_valid", {31'h0, if_valid}, 32'h0);
        chk("async_pc",    {16'h0, IF_PC},    32'h0);
        chk("async_instn", instn,             32'h0);

        // ---- Redirect with two outstanding and one buffered word ----
        mem_auto = 1'b0;
        do_reset();
        mstep(1'b1, 16'h000C, 1'b1, 1'b0, 32'h0);
        chk("rA0_req", {31'h0, s_req}, 32'h0);
        chk("rA0_valid", {31'h0, s_valid}, 32'h0);
        mstep(1'b0, 16'h0, 1'b1, 1'b0, 32'h0);
        chk("rA1_addr", {15'h0, s_req, s_addr}, {15'h0, 1'b1, 16'h000C});
        mstep(1'b0, 16'h0, 1'b1, 1'b0, 32'h0);
        chk("rA2_addr", {15'h0, s_req, s_addr}, {15'h0, 1'b1, 16'h0010});
        mstep(1'b0, 16'h0, 1'b1, 1'b1, word_of(16'h000C));
        chk("rA3_addr", {15'h0, s_req, s_addr}, {15'h0, 1'b1, 16'h0014});
        chk("rA3_valid", {31'h0, s_valid}, 32'h0);
        mstep(1'b1, 16'h0200, 1'b1, 1'b0, 32'h0);
        chk("rA4_req", {31'h0, s_req}, 32'h0);
        chk("rA4_valid", {31'h0, s_valid}, 32'h0);
        chk("rA4_pc", {16'h0, s_pc}, 32'h0);
        chk("rA4_instn", s_instn, 32'h0);
        mstep(1'b0, 16'h0, 1'b1, 1'b1, word_of(16'h0010));
        chk("rA5_addr", {15'h0, s_req, s_addr}, {15'h0, 1'b1, 16'h0200});
        chk("rA5_valid", {31'h0, s_valid}, 32'h0);
        mstep(1'b0, 16'h0, 1'b0, 1'b1, word_of(16'h0014));
        chk("rA6_addr", {15'h0, s_req, s_addr}, {15'h0, 1'b1, 16'h0204});
        chk("rA6_valid", {31'h0, s_valid}, 32'h0);
        mstep(1'b0, 16'h0, 1'b0, 1'b1, word_of(16'h0200));
        chk("rA7_valid", {31'h0, s_valid}, 32'h0);
        mstep(1'b0, 16'h0, 1'b0, 1'b0, 32'h0);
        chk("rA8_valid", {31'h0, s_valid}, 32'h1);
        chk("rA8_pc", {16'h0, s_pc}, 32'h0200);
        chk("rA8_instn", s_instn, word_of(16'h0200));

        // ---- Redirect in a response cycle, then again 2 cycles later ----
        mstep(1'b0, 16'h0, 1'b1, 1'b0, 32'h0);
        chk("rB9_addr", {15'h0, s_req, s_addr}, {15'h0, 1'b1, 16'h0204});
        mstep(1'b1, 16'h0100, 1'b1, 1'b1, word_of(16'h0204));
        chk("rB10_req", {31'h0, s_req}, 32'h0);
        chk("rB10_valid", {31'h0, s_valid}, 32'h0);
        mstep(1'b0, 16'h0, 1'b1, 1'b0, 32'h0);
        chk("rB11_addr", {15'h0, s_req, s_addr}, {15'h0, 1'b1, 16'h0100});
        mstep(1'b1, 16'h0040, 1'b1, 1'b1, word_of(16'h0100));
        chk("rB12_req", {31'h0, s_req}, 32'h0);
        chk("rB12_valid", {31'h0, s_valid}, 32'h0);
        mstep(1'b0, 16'h0, 1'b1, 1'b0, 32'h0);
        chk("rB13_addr", {15'h0, s_req, s_addr}, {15'h0, 1'b1, 16'h0040});
        chk("rB13_valid", {31'h0, s_valid}, 32'h0);
        mstep(1'b0, 16'h0, 1'b0, 1'b1, word_of(16'h0040));
        chk("rB14_valid", {31'h0, s_valid}, 32'h0);
        mstep(1'b0, 16'h0, 1'b0, 1'b0, 32'h0);
        chk("rB15_valid", {31'h0, s_valid}, 32'h1);
        chk("rB15_pc", {16'h0, s_pc}, 32'h0040);
        chk("rB15_instn", s_instn, word_of(16'h0040));
        mstep(1'b0, 16'h0, 1'b0, 1'b0, 32'h0);
        chk("rB16_valid", {31'h0, s_valid}, 32'h0);

        // ---- Random ready and 1-4 cycle latency: in-order, no skips ----
        mem_auto = 1'b1; lat_min = 1; lat_max = 4;
        do_reset();
        accepted = 0; presented = 0; exp_pc = 16'h0;
        for (int k = 0; k < 600 && presented < 60; k++) begin
            imem_ready = 1'($urandom_range(1, 0));
            cycle();
            if (s_req && imem_ready) accepted++;
            if (s_valid) begin
                chk("rnd_pc", {16'h0, s_pc}, {16'h0, exp_pc});
                chk("rnd_instn", s_instn, word_of(exp_pc));
                exp_pc = exp_pc + 16'd4;
                presented++;
            end
            chk("rnd_credit", {31'h0, 1'((accepted - presented) <= 3)}, 32'h1);
        end
        chk("rnd_progress", {31'h0, 1'(presented >= 60)}, 32'h1);

        // ---- Wrap-around instance ----
        mem_auto = 1'b0; imem_rvalid = 1'b0; imem_ready = 1'b0;
        rst1_n = 1'b1;
        cycle();
        chk("wrap0", {15'h0, s1_req, s1_addr}, {15'h0, 1'b1, 16'hFFF8});
        cycle();
        chk("wrap1", {15'h0, s1_req, s1_addr}, {15'h0, 1'b1, 16'hFFFC});
        cycle();
        chk("wrap2", {15'h0, s1_req, s1_addr}, {15'h0, 1'b1, 16'h0000});
        cycle();
        chk("wrap3_req", {31'h0, s1_req}, 32'h0);
        #2;
        rst1_n = 1'b0;
        @(negedge clk);
        rst1_n = 1'b1;
        cycle();
        chk("wrap_restart", {15'h0, s1_req, s1_addr}, {15'h0, 1'b1, 16'hFFF8});
        cycle();
        chk("wrap_restart1", {15'h0, s1_req, s1_addr}, {15'h0, 1'b1, 16'hFFFC});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
